// File: rtl/operand_serializer_if.sv
// Operand serializer bus: controller side (master) drives load/start/stall
// and the parallel operand; serializer side (slave) returns the serial stream.
interface operand_serializer_if #(
    parameter int WIDTH = 8
);
    localparam int IW = $clog2(WIDTH);

    logic             load_en;
    logic [WIDTH-1:0] par_in;
    logic             start;
    logic             stall;
    logic [WIDTH-1:0] operand_bits;
    logic             ser_bit;
    logic             ser_valid;
    logic [IW-1:0]    bit_index;
    logic             last;
    logic             done;
    logic             busy;

    modport master (
        output load_en, par_in, start, stall,
        input  operand_bits, ser_bit, ser_valid,
        input  bit_index, last, done, busy
    );

    modport slave (
        input  load_en, par_in, start, stall,
        output operand_bits, ser_bit, ser_valid,
        output bit_index, last, done, busy
    );
endinterface

// File: rtl/operand_serializer.sv
// Bit-serial operand source: captures a parallel operand and streams it
// LSB first with bit index, last-bit flag and a one-cycle done pulse.
// Ports: clk, rst_n (sync, active-low), bus (operand_serializer_if.slave):
//   in  load_en, par_in, start, stall
//   out operand_bits, ser_bit, ser_valid, bit_index, last, done, busy
// Option: define SER_RECIRC_EN to rotate instead of zero-fill, leaving
// the operand intact after a complete stream.
module operand_serializer #(
    parameter int WIDTH = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    operand_serializer_if.slave bus
);
    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST_IDX = IW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] bits_q, bits_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             fill;

`ifdef SER_RECIRC_EN
    assign fill = bits_q[0];
`else
    assign fill = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bits_q  <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            bits_q  <= bits_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bits_d  = bits_q;
        idx_d   = idx_q;
        if (bus.load_en) begin
            state_d = IDLE;
            bits_d  = bus.par_in;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        state_d = SHIFT;
                        idx_d   = '0;
                    end
                end
                SHIFT: begin
                    if (!bus.stall) begin
                        bits_d = {fill, bits_q[WIDTH-1:1]};
                        if (idx_q == LAST_IDX) begin
                            state_d = DONE;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end
                end
                DONE: begin
                    // start here chains the next stream with no gap
                    state_d = bus.start ? SHIFT : IDLE;
                    idx_d   = '0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign bus.operand_bits = bits_q;
    assign bus.ser_bit      = bits_q[0];
    assign bus.ser_valid    = (state_q == SHIFT);
    assign bus.bit_index    = idx_q;
    assign bus.last         = (state_q == SHIFT) && (idx_q == LAST_IDX);
    assign bus.done         = (state_q == DONE);
    assign bus.busy         = (state_q != IDLE);
endmodule

// File: doc/operand_serializer.md
# operand_serializer

Bit-serial operand source for the bit-serial datapath. It captures a parallel operand and presents it to the serial ALU one bit per cycle, LSB first, with a bit index, last-bit flag and completion pulse. It is the read-side counterpart of the accumulator, which collects ALU result bits serially. The controller loads the operand, issues `start`, and may stall the stream.

## Interface
- `WIDTH`, default 8: operand width in bits. Must be a power of two and ≥ 2.
- `clk` in 1: clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `load_en` in 1: parallel capture of `par_in`. Aborts any stream in progress.
- `par_in` in WIDTH: parallel operand.
- `start` in 1: begin streaming. Honoured only in IDLE or DONE.
- `stall` in 1: freeze the stream. Current bit, index and register hold.
- `operand_bits` out WIDTH: shift register contents.
- `ser_bit` out 1: current serial bit, `operand_bits[0]` (combinational from register).
- `ser_valid` out 1: high in SHIFT.
- `bit_index` out $clog2(WIDTH): index of the bit currently presented.
- `last` out 1: `ser_valid && bit_index == WIDTH-1`.
- `done` out 1: high in DONE (one-cycle pulse).
- `busy` out 1: high in SHIFT or DONE.

## Operation
- States: IDLE, SHIFT, DONE. Encoding is free.
- Priority each cycle: reset > `load_en` > `stall` > normal advance.
- Reset: state IDLE, `operand_bits`=0, `bit_index`=0. All outputs are 0 at reset.
- `load_en`=1 in any state: `operand_bits` ← `par_in`, `bit_index` ← 0, state → IDLE. `start` in the same cycle is ignored.
- IDLE:
  - `start`=1 → SHIFT, `bit_index` ← 0, register unchanged.
  - Otherwise hold.
- SHIFT with `stall`=1: everything holds. `ser_valid` stays 1. `last` is re-asserted if the index is WIDTH-1.
- SHIFT with `stall`=0:
  - `operand_bits` ← {fill, `operand_bits[WIDTH-1:1]`}.
  - `bit_index` ← `bit_index`+1.
  - When `bit_index` == WIDTH-1, state → DONE and `bit_index` ← 0 (wrap; no extra bit).
- SHIFT: `start` is ignored.
- DONE:
  - `done`=1 for exactly one cycle. `stall` is ignored.
  - `start`=1 → SHIFT (back-to-back stream, `bit_index`=0). Otherwise → IDLE.
- Fill bit: 0 by default (see Configuration).
- `operand_bits` changes only on reset, load, or an unstalled SHIFT cycle.

## Timing
- `start` sampled at edge N → `ser_valid`=1 and bit 0 valid from edge N+1.
- No stalls: bit k is valid in cycle N+1+k. `last` is high in cycle N+WIDTH. `done` is high in cycle N+WIDTH+1.
- Each stalled cycle delays all later bits, `last` and `done` by one cycle.
- Back-to-back: `start` asserted during DONE gives the next stream's bit 0 in the cycle after DONE. The minimum stream period is WIDTH+1 cycles.
- `load_en` during SHIFT: `ser_valid` drops in the next cycle and `done` never pulses for the aborted stream.
- Reset during SHIFT or DONE: next cycle in IDLE with all outputs 0; no `done` pulse.

## Configuration
- `SER_RECIRC_EN` defined: the fill bit is the outgoing bit `operand_bits[0]` (rotate right). After a complete stream, `operand_bits` equals its pre-stream value, so the operand can be re-streamed without reload.
- `SER_RECIRC_EN` undefined: the fill is 0. After a complete stream, `operand_bits` = 0.

## Test plan
- Basic stream: reset, load `par_in`=0xA5, `start` one cycle.
  - `ser_bit` over 8 valid cycles = 1,0,1,0,0,1,0,1.
  - `bit_index` = 0..7; `last` only on index 7; `done` one cycle later.
  - Final `operand_bits` = 0x00, or 0xA5 with `SER_RECIRC_EN`.
- Stall: load 0x3C, start, assert `stall` for 3 cycles at index 2.
  - Index 2 and `ser_bit`=1 hold for 4 cycles total.
  - `done` is 3 cycles later than in the unstalled case.
  - Bit sequence unchanged: 0,0,1,1,1,1,0,0.
- Abort: load 0xFF, start, assert `load_en` with `par_in`=0x0F at index 4.
  - Next cycle: IDLE, `operand_bits`=0x0F, `ser_valid`=0, no `done` pulse.
- Reset mid-stream: load 0x81, start, drop `rst_n` at index 5.
  - Next cycle: all outputs 0, IDLE; a subsequent `start` streams 0x00.
- Back-to-back with `SER_RECIRC_EN`: load 0x96, start, reassert `start` during DONE.
  - The second stream follows immediately and repeats 0,1,1,0,1,0,0,1.
  - Two `done` pulses 9 cycles apart.
